// File: rtl/dac_mixer_sched_if.sv
// -----------------------------------------------------------------------------
// dac_mixer_sched_if
//   Sample request bundle between the requesters and the DAC mixer scheduler.
//   One valid/ready pair per channel. Channel i's data sits at s_data[i*DW +: DW].
//
//   Signals
//     s_valid  [CHANNELS]     requester i offers a sample
//     s_data   [CHANNELS*DW]  signed samples, channel-sliced
//     s_ready  [CHANNELS]     mixer can take a sample on channel i
//
//   Modports
//     master : requester side (drives valid/data, sees ready)
//     slave  : mixer side     (sees valid/data, drives ready)
// -----------------------------------------------------------------------------
interface dac_mixer_sched_if #(
    parameter int CHANNELS = 4,
    parameter int DW       = 8
);
    logic [CHANNELS-1:0]    s_valid;
    logic [CHANNELS*DW-1:0] s_data;
    logic [CHANNELS-1:0]    s_ready;

    modport master (output s_valid, output s_data, input  s_ready);
    modport slave  (input  s_valid, input  s_data, output s_ready);
endinterface

// File: rtl/dac_mixer_sched.sv
// -----------------------------------------------------------------------------
// dac_mixer_sched
//   Sample scheduler and mixer in front of the delta-sigma DAC. Each channel
//   owns a one-sample holding slot. Every DIV clocks a sequence starts that
//   multiply-accumulates one channel per clock with its volume, shifts the sum
//   down by VW, saturates it to OW bits and presents it in excess-2^(OW-1)
//   form together with a one-cycle frame strobe. A channel with no fresh
//   sample at its slot repeats its last sample and raises a sticky underrun.
//
//   Ports
//     clock         system clock
//     reset         asynchronous, active-high reset
//     sif           slave side of the per-channel sample handshake
//     vol           unsigned per-channel volume, channel i at [i*VW +: VW]
//     mute          force midscale on the output (channels still consumed)
//     underrun_clr  clear all sticky underrun flags (a same-edge set wins)
//     dac_d         DAC input word, excess-2^(OW-1)
//     frame         one-cycle pulse in the cycle dac_d takes a new value
//     underrun      sticky per-channel underrun flags
// -----------------------------------------------------------------------------
module dac_mixer_sched #(
    parameter int CHANNELS = 4,
    parameter int DW       = 8,
    parameter int VW       = 6,
    parameter int OW       = 8,
    parameter int DIV      = 16
) (
    input  logic                   clock,
    input  logic                   reset,
    dac_mixer_sched_if.slave       sif,
    input  logic [CHANNELS*VW-1:0] vol,
    input  logic                   mute,
    input  logic                   underrun_clr,
    output logic [OW-1:0]          dac_d,
    output logic                   frame,
    output logic [CHANNELS-1:0]    underrun
);

    localparam int PW = DW + VW + 1;                 // signed x zero-extended volume
    localparam int AW = PW + $clog2(CHANNELS);       // sum of CHANNELS products cannot overflow
    localparam int IW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    localparam logic signed [AW-1:0] SAT_MAX  = AW'((2 ** (OW - 1)) - 1);
    localparam logic signed [AW-1:0] SAT_MIN  = AW'(-(2 ** (OW - 1)));
    localparam logic [OW-1:0]        MIDSCALE = {1'b1, {(OW - 1){1'b0}}};
    localparam logic [IW-1:0]        IDX_LAST = IW'(CHANNELS - 1);
    localparam logic [CW-1:0]        CNT_LAST = CW'(DIV - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MAC  = 2'd1,
        ST_SAT  = 2'd2
    } state_e;

    // State
    state_e                          state_q, state_d;
    logic [CW-1:0]                   cnt_q, cnt_d;
    logic [IW-1:0]                   idx_q, idx_d;
    logic signed [AW-1:0]            acc_q, acc_d;
    logic [CHANNELS-1:0][DW-1:0]     hold_q, hold_d;
    logic [CHANNELS-1:0]             full_q, full_d;
    logic [OW-1:0]                   out_q, out_d;
    logic                            frame_q, frame_d;
    logic [CHANNELS-1:0]             underrun_q, underrun_d;

    // Datapath helpers
    logic                            tick;
    logic [VW-1:0]                   vol_arr [CHANNELS];
    logic signed [PW-1:0]            prod;
    logic signed [AW-1:0]            shifted;
    logic signed [AW-1:0]            clamped;

    assign tick = (cnt_q == CNT_LAST);

    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            vol_arr[i] = vol[i*VW +: VW];
        end
    end

    // NOTE: every signal written here gets a default before any branch, so no
    // path leaves it unassigned and no latch is inferred. Combinational blocks
    // use blocking '=' so later statements see the values computed above them.
    always_comb begin
        state_d    = state_q;
        cnt_d      = tick ? '0 : cnt_q + 1'b1;
        idx_d      = idx_q;
        acc_d      = acc_q;
        hold_d     = hold_q;
        full_d     = full_q;
        out_d      = out_q;
        frame_d    = 1'b0;
        underrun_d = underrun_clr ? '0 : underrun_q;

        prod    = PW'($signed(hold_q[idx_q])) * PW'($signed({1'b0, vol_arr[idx_q]}));
        shifted = acc_q >>> VW;
        if (shifted > SAT_MAX) begin
            clamped = SAT_MAX;
        end else if (shifted < SAT_MIN) begin
            clamped = SAT_MIN;
        end else begin
            clamped = shifted;
        end

        // Accept into empty slots. A full slot holds ready low, so an accept
        // never lands on the same edge as that channel's consume below.
        for (int i = 0; i < CHANNELS; i++) begin
            if (sif.s_valid[i] && !full_q[i]) begin
                hold_d[i] = sif.s_data[i*DW +: DW];
                full_d[i] = 1'b1;
            end
        end

        unique case (state_q)
            ST_IDLE: begin
                if (tick) begin
                    acc_d   = '0;
                    idx_d   = '0;
                    state_d = ST_MAC;
                end
            end
            ST_MAC: begin
                acc_d = acc_q + AW'(prod);
                // A starved channel repeats its stale sample; the flag set
                // comes after the clear default so a same-edge set wins.
                if (full_q[idx_q]) begin
                    full_d[idx_q] = 1'b0;
                end else begin
                    underrun_d[idx_q] = 1'b1;
                end
                if (idx_q == IDX_LAST) begin
                    state_d = ST_SAT;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            ST_SAT: begin
                // Two's complement to excess-2^(OW-1): flip the sign bit.
                out_d   = mute ? MIDSCALE : {~clamped[OW-1], clamped[OW-2:0]};
                frame_d = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking '<=' so every register samples
    // the pre-edge values of the others, independent of statement order.
    // The holding slots are reset too: an underrun before any sample arrives
    // repeats hold, so its content must be defined (zero) out of reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            idx_q      <= '0;
            acc_q      <= '0;
            hold_q     <= '0;
            full_q     <= '0;
            out_q      <= MIDSCALE;
            frame_q    <= 1'b0;
            underrun_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            acc_q      <= acc_d;
            hold_q     <= hold_d;
            full_q     <= full_d;
            out_q      <= out_d;
            frame_q    <= frame_d;
            underrun_q <= underrun_d;
        end
    end

    assign sif.s_ready = ~full_q;
    assign dac_d       = out_q;
    assign frame       = frame_q;
    assign underrun    = underrun_q;

endmodule

// File: tb/tb_dac_mixer_sched.sv
// -----------------------------------------------------------------------------
// tb_dac_mixer_sched
//   Self-checking bench for dac_mixer_sched (CHANNELS=4, DW=8, VW=6, OW=8,
//   DIV=16). A reference model tracks cycle index since reset, each channel's
//   slot, the stale-sample repeat and the underrun flags, and at the end of
//   each mix computes floor(sum/2^VW), clamps it and offsets it by midscale.
//   Expected frames go into a queue; a monitor on the falling edge pops and
//   compares whenever the DUT raises frame, and checks ready/underrun/dac_d
//   every cycle against the model.
// -----------------------------------------------------------------------------
module tb_dac_mixer_sched;

    localparam int CH  = 4;
    localparam int DW  = 8;
    localparam int VW  = 6;
    localparam int OW  = 8;
    localparam int DIV = 16;

    logic                 clock = 1'b0;
    logic                 reset = 1'b1;
    logic [CH*VW-1:0]     vol;
    logic                 mute;
    logic                 underrun_clr;
    logic [OW-1:0]        dac_d;
    logic                 frame;
    logic [CH-1:0]        underrun;

    dac_mixer_sched_if #(.CHANNELS(CH), .DW(DW)) sif ();

    dac_mixer_sched #(
        .CHANNELS(CH), .DW(DW), .VW(VW), .OW(OW), .DIV(DIV)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .sif          (sif),
        .vol          (vol),
        .mute         (mute),
        .underrun_clr (underrun_clr),
        .dac_d        (dac_d),
        .frame        (frame),
        .underrun     (underrun)
    );

    always #5 clock = ~clock;

    int vectors     = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        int            cyc;
        logic [OW-1:0] dac;
        logic [CH-1:0] und;
    } frame_t;

    frame_t        exp_q[$];
    bit            m_full    [CH];
    int            m_hold    [CH];
    int            m_contrib [CH];
    logic [CH-1:0] m_und;
    logic [OW-1:0] m_dac;
    int            cyc;   // cycle index since reset release; cycle 0 follows release

    function automatic void model_reset();
        for (int i = 0; i < CH; i++) begin
            m_full[i]    = 1'b0;
            m_hold[i]    = 0;
            m_contrib[i] = 0;
        end
        m_und = '0;
        m_dac = 8'h80;
        cyc   = 0;
        exp_q.delete();
    endfunction

    // Ticks fall in cycles 15, 31, ...; channel k mixes in cycle 16n+k and the
    // result is formed in cycle 16n+CH, appearing on the output one cycle later.
    always @(posedge clock) begin : model
        int     ph;
        int     sum;
        int     s;
        bit     full_pre [CH];
        frame_t f;
        if (reset) begin
            model_reset();
        end else begin
            ph       = cyc % DIV;
            full_pre = m_full;
            if (underrun_clr) m_und = '0;
            if (cyc >= DIV && ph < CH) begin
                m_contrib[ph] = m_hold[ph] * int'(vol[ph*VW +: VW]);
                if (m_full[ph]) m_full[ph] = 1'b0;
                else            m_und[ph]  = 1'b1;
            end
            for (int i = 0; i < CH; i++) begin
                if (sif.s_valid[i] && !full_pre[i]) begin
                    m_hold[i] = int'($signed(sif.s_data[i*DW +: DW]));
                    m_full[i] = 1'b1;
                end
            end
            if (cyc >= DIV && ph == CH) begin
                sum = 0;
                for (int i = 0; i < CH; i++) sum += m_contrib[i];
                s = sum >>> VW;
                if (s > 127)  s = 127;
                if (s < -128) s = -128;
                m_dac = mute ? 8'h80 : 8'(s + 128);
                f.cyc = cyc + 1;
                f.dac = m_dac;
                f.und = m_und;
                exp_q.push_back(f);
            end
            cyc++;
        end
    end

    // ---------------- monitor ----------------
    always @(negedge clock) begin : monitor
        logic [CH-1:0] rdy_exp;
        frame_t        f;
        if (!reset) begin
            for (int i = 0; i < CH; i++) rdy_exp[i] = ~m_full[i];
            check("s_ready", sif.s_ready, rdy_exp);
            check("underrun", underrun, m_und);
            check("dac_d", dac_d, m_dac);
            if (frame) begin
                if (exp_q.size() == 0) begin
                    check("frame_unexpected", frame, 1'b0);
                end else begin
                    f = exp_q.pop_front();
                    check("frame_cycle", cyc, f.cyc);
                    check("frame_dac", dac_d, f.dac);
                    check("frame_underrun", underrun, f.und);
                end
            end else if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
                check("frame_missing", frame, 1'b1);
                exp_q.delete(0);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic idle_inputs();
        sif.s_valid  = '0;
        sif.s_data   = '0;
        underrun_clr = 1'b0;
    endtask

    task automatic set_vol(input int ch, input int v);
        vol[ch*VW +: VW] = VW'(v);
    endtask

    // Block until the falling edge inside cycle phase p of a running frame.
    task automatic wait_phase(input int p);
        int n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (!(cyc >= DIV && cyc % DIV == p) && n < 3 * DIV);
        if (!(cyc >= DIV && cyc % DIV == p)) begin
            vectors++;
            miscompares++;
            $display("FAIL wait_phase: phase %0d not reached within %0d cycles", p, n);
        end
    endtask

    task automatic pulse_sample(input int ch, input logic [DW-1:0] d);
        sif.s_valid[ch]         = 1'b1;
        sif.s_data[ch*DW +: DW] = d;
        @(negedge clock);
        sif.s_valid[ch] = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_dac"},      dac_d,       8'h80);
        check({tag, "_frame"},    frame,       1'b0);
        check({tag, "_s_ready"},  sif.s_ready, 4'hF);
        check({tag, "_underrun"}, underrun,    4'h0);
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- stimulus ----------------
    initial begin : stim
        mute = 1'b0;
        vol  = '0;
        idle_inputs();
        repeat (3) @(negedge clock);
        #2 reset = 1'b0;
        #1 check_reset_outputs("reset_release");

        // Idle until the first frame (cycle 21): midscale, all channels starved.
        repeat (24) @(negedge clock);

        // One sample 0x40 on ch0 at half gain.
        set_vol(0, 32);
        wait_phase(CH + 1);
        pulse_sample(0, 8'h40);
        wait_phase(CH + 2);

        // Positive then negative saturation, every channel at full volume.
        for (int i = 0; i < CH; i++) set_vol(i, 63);
        sif.s_valid = '1;
        sif.s_data  = {CH{8'h7F}};
        repeat (2 * DIV) @(negedge clock);
        sif.s_data  = {CH{8'h80}};
        repeat (2 * DIV) @(negedge clock);
        idle_inputs();

        // Repeat of a stale sample and underrun set/clear precedence.
        vol = '0;
        set_vol(0, 32);
        wait_phase(CH + 2);
        pulse_sample(0, 8'h40);
        repeat (2 * DIV) @(negedge clock);
        underrun_clr = 1'b1;
        @(negedge clock);
        underrun_clr = 1'b0;
        wait_phase(0);
        underrun_clr = 1'b1;        // lands on ch0's starved slot: set wins
        @(negedge clock);
        underrun_clr = 1'b0;
        wait_phase(CH + 2);

        // Back-pressure: ch1 offers a new sample every cycle.
        set_vol(1, $urandom_range(1, 63));
        sif.s_valid[1] = 1'b1;
        for (int k = 0; k < 3 * DIV; k++) begin
            sif.s_data[1*DW +: DW] = DW'($urandom);
            @(negedge clock);
        end
        idle_inputs();

        // Mute: sample still consumed, output forced to midscale.
        vol = '0;
        set_vol(0, 32);
        mute = 1'b1;
        wait_phase(CH + 2);
        pulse_sample(0, 8'h40);
        wait_phase(CH + 2);
        mute = 1'b0;

        // Reset in the middle of the mix (ch2 slot).
        pulse_sample(0, 8'h33);
        wait_phase(2);
        #2 reset = 1'b1;
        model_reset();
        #1 check_reset_outputs("reset_mid_mac");
        repeat (2) @(negedge clock);
        #2 reset = 1'b0;
        repeat (DIV + CH + 4) @(negedge clock);

        // Randomized traffic.
        for (int k = 0; k < 640; k++) begin
            for (int i = 0; i < CH; i++) begin
                sif.s_valid[i]          = ($urandom_range(0, 3) != 0);
                sif.s_data[i*DW +: DW]  = DW'($urandom);
                if ($urandom_range(0, 15) == 0) set_vol(i, $urandom_range(0, 63));
            end
            mute         = ($urandom_range(0, 7) == 0);
            underrun_clr = ($urandom_range(0, 9) == 0);
            @(negedge clock);
        end
        idle_inputs();
        mute = 1'b0;

        // Drain and make sure every predicted frame was seen.
        repeat (2 * DIV) @(negedge clock);
        check("scoreboard_empty", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
